// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared constants for the bit-serial adder
package serial_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_ADD  = 1'b1;

  localparam int SERIAL_W = 8;

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/done request bus between controller and serial adder
interface serial_adder_if import serial_pkg::*; #(parameter int WIDTH = SERIAL_W);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);

endinterface

// File: rtl/FA.sv
// rtl/FA.sv - combinational full-adder cell
module FA (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic ca
);

  assign s  = a ^ b ^ c;
  assign ca = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one bit per clock through a single FA cell
module serial_adder import serial_pkg::*; #(
  parameter int WIDTH = SERIAL_W
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  logic             state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             fa_s, fa_ca;
  logic [WIDTH-1:0] s_next;

  FA u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .c  (carry_q),
    .s  (fa_s),
    .ca (fa_ca)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the result sits at bit 0.
  assign s_next = (s_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          s_sh_d  = '0;
          state_d = ST_ADD;
        end
      end
      default: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        s_sh_d  = s_next;
        carry_d = fa_ca;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = s_next;
          cout_d  = fa_ca;
          // carry_q is the carry into the MSB during the final bit cycle
          ovf_d   = carry_q ^ fa_ca;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == ST_ADD);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
